// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad row scanner with per-frame observation and
// frame-based press/release debouncing.
module keypad_scan_debounce #(
  parameter int SCAN_DIV        = 250000,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] keypadCol,
  output logic [3:0] keypadRow,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       key_release,
  output logic       frame_tick
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DF = CW'(DEBOUNCE_FRAMES);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE, PRESS_CHK, HELD, REL_CHK
  } state_t;

  typedef enum logic [1:0] {
    OBS_NONE, OBS_KEY, OBS_MULTI
  } obs_t;

  state_t        state;
  logic [SW-1:0] slot;
  logic [1:0]    row;
  logic [1:0]    acc_n;
  logic [3:0]    acc_key;
  logic [3:0]    cand;
  logic [CW-1:0] cnt;

  logic [3:0]    low;
  logic [1:0]    low_n;
  logic [1:0]    low_col;
  logic [1:0]    sum_n;
  logic [3:0]    samp_key;
  logic [3:0]    obs_key;
  obs_t          obs;
  logic          slot_end;
  logic          frame_end;
  logic [CW-1:0] cnt_inc;

  function automatic logic [3:0] keymap(
    input logic [1:0] r,
    input logic [1:0] c
  );
    logic [3:0] k;
    unique case ({r, c})
      4'h0: k = 4'h7;
      4'h1: k = 4'h4;
      4'h2: k = 4'h1;
      4'h3: k = 4'h0;
      4'h4: k = 4'h8;
      4'h5: k = 4'h5;
      4'h6: k = 4'h2;
      4'h7: k = 4'hA;
      4'h8: k = 4'h9;
      4'h9: k = 4'h6;
      4'hA: k = 4'h3;
      4'hB: k = 4'hB;
      4'hC: k = 4'hC;
      4'hD: k = 4'hD;
      4'hE: k = 4'hE;
      4'hF: k = 4'hF;
    endcase
    return k;
  endfunction

  assign low       = ~keypadCol;
  assign slot_end  = (slot == SLOT_LAST);
  assign frame_end = slot_end && (row == 2'd3);
  assign cnt_inc   = (cnt >= DF) ? cnt : cnt + ONE;

  // Saturating low-bit count (0, 1, 2+) and column of a lone low bit
  always_comb begin
    low_n   = 2'd0;
    low_col = 2'd0;
    for (int c = 3; c >= 0; c--) begin
      if (low[c]) begin
        low_col = 2'(c);
        if (low_n != 2'd2) low_n = low_n + 2'd1;
      end
    end
  end

  always_comb begin
    sum_n = 2'd2;
    if (acc_n == 2'd0) sum_n = low_n;
    else if (acc_n == 2'd1 && low_n == 2'd0) sum_n = 2'd1;
  end

  assign samp_key = keymap(row, low_col);
  assign obs_key  = (acc_n == 2'd1) ? acc_key : samp_key;

  always_comb begin
    obs = OBS_MULTI;
    if (sum_n == 2'd0) obs = OBS_NONE;
    else if (sum_n == 2'd1) obs = OBS_KEY;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      slot        <= '0;
      row         <= 2'd0;
      keypadRow   <= 4'b1110;
      acc_n       <= 2'd0;
      acc_key     <= 4'd0;
      cand        <= 4'd0;
      cnt         <= '0;
      key_code    <= 4'd0;
      key_valid   <= 1'b0;
      key_held    <= 1'b0;
      key_release <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      frame_tick  <= frame_end;
      slot        <= slot_end ? '0 : slot + 1'b1;

      if (slot_end) begin
        row       <= row + 2'd1;
        keypadRow <= ~(4'b0001 << (row + 2'd1));
        if (frame_end) begin
          acc_n   <= 2'd0;
          acc_key <= 4'd0;
        end else begin
          acc_n <= sum_n;
          if (acc_n == 2'd0 && low_n == 2'd1) acc_key <= samp_key;
        end
      end

      if (frame_end) begin
        case (state)
          IDLE: begin
            if (obs == OBS_KEY) begin
              cand <= obs_key;
              cnt  <= ONE;
              if (ONE >= DF) begin
                key_code  <= obs_key;
                key_held  <= 1'b1;
                key_valid <= 1'b1;
                state     <= HELD;
              end else begin
                state <= PRESS_CHK;
              end
            end
          end
          PRESS_CHK: begin
            if (obs == OBS_KEY && obs_key == cand) begin
              cnt <= cnt_inc;
              if (cnt_inc >= DF) begin
                key_code  <= cand;
                key_held  <= 1'b1;
                key_valid <= 1'b1;
                state     <= HELD;
              end
            end else if (obs == OBS_KEY) begin
              cand <= obs_key;
              cnt  <= ONE;
            end else begin
              state <= IDLE;
            end
          end
          HELD: begin
            if (obs == OBS_NONE) begin
              cnt <= ONE;
              if (ONE >= DF) begin
                key_held    <= 1'b0;
                key_release <= 1'b1;
                state       <= IDLE;
              end else begin
                state <= REL_CHK;
              end
            end else if (obs == OBS_MULTI || obs_key != key_code) begin
              cnt   <= '0;
              state <= REL_CHK;
            end
          end
          REL_CHK: begin
            if (obs == OBS_NONE) begin
              cnt <= cnt_inc;
              if (cnt_inc >= DF) begin
                key_held    <= 1'b0;
                key_release <= 1'b1;
                state       <= IDLE;
              end
            end else if (obs == OBS_KEY && obs_key == key_code) begin
              state <= HELD;
            end else begin
              cnt <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/keypad_scan_debounce.md
Name: keypad_scan_debounce

Overview:
- Upstream stage for the dot-matrix key display. Scans the 4x4 matrix keypad one row at a time and samples the active-low columns.
- Resolves each full 4-row scan frame into one observation, then debounces across consecutive frames.
- Outputs a stable 4-bit key code with a one-cycle press strobe, a held level and a one-cycle release strobe. The display stage consumes these instead of scanning raw columns.

Parameters:
- SCAN_DIV, 250000, clock cycles per row slot; minimum 2.
- DEBOUNCE_FRAMES, 3, consecutive identical frames required to accept a press or release; minimum 1.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- keypadCol  in  4  column sense, active-low; bit c = column c
- keypadRow  out  4  row drive, one-hot-low
- key_code  out  4  last accepted key code; holds its value after release
- key_valid  out  1  one-cycle pulse when a press is accepted
- key_held  out  1  high while the accepted key is considered down
- key_release  out  1  one-cycle pulse when a release is accepted
- frame_tick  out  1  one-cycle pulse on the cycle after each frame end

Behaviour:
- Reset (clock edge with reset=0): keypadRow=4'b1110, row index=0, slot counter=0, key_code=0, key_valid=0, key_held=0, key_release=0, frame_tick=0, state IDLE, frame accumulators and debounce count cleared. Reset applied mid-frame or mid-debounce aborts everything; no strobes are emitted.
- Scan:
  - The slot counter runs 0..SCAN_DIV-1, then wraps.
  - keypadRow = ~(1<<row index), registered.
  - On slot==SCAN_DIV-1, keypadCol is sampled for the current row, and row index advances 0->1->2->3->0 on the next cycle.
- Frame end E is the cycle with row index=3 and slot=SCAN_DIV-1. Frame length is 4*SCAN_DIV cycles.
- Key map (row index r, column c with keypadCol[c]=0):
  - r0: c0..c3 = 7,4,1,0
  - r1: 8,5,2,A
  - r2: 9,6,3,B
  - r3: C,D,E,F
- Frame observation, formed over the 4 samples of a frame:
  - NONE: no low column seen.
  - KEY(k): exactly one low bit in the whole frame.
  - MULTI: two or more low bits.
- FSM, evaluated at E, with all outputs registered and updated at E+1:
  - IDLE: on KEY(k), set cand=k, cnt=1. If cnt>=DEBOUNCE_FRAMES, accept the press; otherwise go to PRESS_CHK. NONE or MULTI stays in IDLE.
  - PRESS_CHK:
    - KEY(cand): cnt+1; on reaching DEBOUNCE_FRAMES, accept the press.
    - KEY(j) with j!=cand: cand=j, cnt=1.
    - NONE or MULTI: go to IDLE.
  - Press accept: key_code=cand, key_held=1, key_valid=1 for the E+1 cycle only, go to HELD.
  - HELD:
    - KEY(key_code): stay.
    - NONE: cnt=1. If cnt>=DEBOUNCE_FRAMES, accept the release; otherwise go to REL_CHK.
    - KEY(j!=key_code) or MULTI: go to REL_CHK with cnt=0.
  - REL_CHK:
    - NONE: cnt+1; on reaching DEBOUNCE_FRAMES, accept the release.
    - KEY(key_code): go back to HELD (bounce), no strobe.
    - Other KEY or MULTI: cnt=0, stay.
  - Release accept: key_held=0, key_release=1 for one cycle, go to IDLE. key_code is unchanged.
- A new key always requires an accepted release first; there is no rollover.
- Latency: a press held steady from frame start is accepted at the E of frame DEBOUNCE_FRAMES. key_valid rises at that E+1.
- key_valid and key_release are never high together. Strobes are never longer than one cycle.
- frame_tick=1 at every E+1, independent of FSM state.
- Counter widths: slot counter is $clog2(SCAN_DIV) bits; cnt is wide enough to hold DEBOUNCE_FRAMES and saturates there.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE_FRAMES=3 (frame = 16 cycles).
- Reset, then idle keypad (all columns 4'b1111):
  - keypadRow reads 1110 on cycles 0..3, then 1101, 1011, 0111, then 1110 again.
  - frame_tick pulses every 16 cycles.
  - No key strobes occur.
- Bench drives keypadCol=4'b1011 whenever keypadRow=4'b1101 for 3 full frames:
  - key_valid high for exactly 1 cycle at the end of the 3rd frame, with key_code=2 and key_held=1.
  - Then release for 3 frames: key_release pulses once, key_held=0, key_code stays 2.
- Bounce: key F (row 0111, col 0111) pressed 2 frames, released 1 frame, pressed 3 frames:
  - exactly one key_valid, issued at the end of the 6th frame, with code F.
- MULTI: keys 7 and 5 both pressed for 5 frames:
  - no key_valid, key_held stays 0.
  - Then 5 alone for 3 frames: key_valid with code 5.
- Direct change: hold 9 until accepted, then switch to 3 without a NONE frame for 4 frames:
  - key_held stays 1, code stays 9, no key_valid.
  - After 3 NONE frames: key_release pulses.
  - Pressing 3 again for 3 frames gives key_valid with code 3.
- Reset asserted in REL_CHK mid-frame:
  - Next cycle: all outputs at reset values and keypadRow=1110.
  - No release strobe.
